// File: rtl/wash_control_panel.sv
// rtl/wash_control_panel.sv - coin/program front panel driving the washing-machine FSM
module wash_control_panel #(
    parameter int CREDIT_W      = 4,
    parameter int PRICE_NORMAL  = 2,
    parameter int PRICE_DOUBLE  = 3,
    parameter int PRICE_DRY     = 2,
    parameter int ACK_TIMEOUT   = 4,
    parameter int PAUSE_LOCKOUT = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin,
    input  logic                sel_double,
    input  logic                sel_dry,
    input  logic                start_btn,
    input  logic                pause_btn,
    input  logic                cancel_btn,
    input  logic                done,
    output logic                start,
    output logic                double_wash,
    output logic                dry_wash,
    output logic                time_pause,
    output logic [CREDIT_W-1:0] credit,
    output logic                refund,
    output logic [CREDIT_W-1:0] refund_amt,
    output logic                err_funds,
    output logic                busy
);
    localparam int LOCK_W = $clog2(PAUSE_LOCKOUT + 1);
    localparam int ACK_W  = $clog2(ACK_TIMEOUT + 1);
    localparam logic [ACK_W-1:0]  ACK_LAST  = ACK_W'(ACK_TIMEOUT - 1);
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(PAUSE_LOCKOUT);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_ACK, RUN} state_t;

    state_t              state, state_next;
    logic [CREDIT_W-1:0] price, paid, paid_next;
    logic [CREDIT_W-1:0] credit_next, refund_amt_next, credit_sat, launch_sat;
    logic [CREDIT_W:0]   credit_inc, launch_diff;
    logic [LOCK_W-1:0]   lockout, lock_next;
    logic [ACK_W-1:0]    ack_cnt, ack_next;
    logic                start_next, double_next, dry_next, pause_next;
    logic                refund_next, err_next, busy_next;

    always_comb begin
        if (sel_dry)
            price = CREDIT_W'(PRICE_DRY);
        else if (sel_double)
            price = CREDIT_W'(PRICE_DOUBLE);
        else
            price = CREDIT_W'(PRICE_NORMAL);
    end

    // Widen by one bit so a coin at full credit is detected and discarded
    assign credit_inc  = {1'b0, credit} + (CREDIT_W+1)'(coin);
    assign launch_diff = credit_inc - {1'b0, price};
    assign credit_sat  = credit_inc[CREDIT_W]  ? {CREDIT_W{1'b1}} : credit_inc[CREDIT_W-1:0];
    assign launch_sat  = launch_diff[CREDIT_W] ? {CREDIT_W{1'b1}} : launch_diff[CREDIT_W-1:0];

    always_comb begin
        state_next      = state;
        credit_next     = credit_sat;
        double_next     = double_wash;
        dry_next        = dry_wash;
        paid_next       = paid;
        ack_next        = ack_cnt;
        lock_next       = (lockout != '0) ? lockout - 1'b1 : '0;
        start_next      = 1'b0;
        pause_next      = 1'b0;
        refund_next     = 1'b0;
        refund_amt_next = '0;
        err_next        = 1'b0;
        case (state)
            IDLE: begin
                if (cancel_btn) begin
                    refund_next     = 1'b1;
                    refund_amt_next = credit_sat;
                    credit_next     = '0;
                end else if (start_btn) begin
                    if (credit >= price && done) begin
                        state_next  = LAUNCH;
                        start_next  = 1'b1;
                        double_next = sel_double & ~sel_dry;
                        dry_next    = sel_dry;
                        paid_next   = price;
                        credit_next = launch_sat;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            LAUNCH: begin
                state_next = WAIT_ACK;
                ack_next   = '0;
            end
            WAIT_ACK: begin
                if (!done) begin
                    state_next = RUN;
                end else if (ack_cnt == ACK_LAST) begin
                    // Machine never acknowledged: return the price, keep leftover credit
                    state_next      = IDLE;
                    refund_next     = 1'b1;
                    refund_amt_next = paid;
                    double_next     = 1'b0;
                    dry_next        = 1'b0;
                end else begin
                    ack_next = ack_cnt + 1'b1;
                end
            end
            RUN: begin
                if (done) begin
                    state_next  = IDLE;
                    double_next = 1'b0;
                    dry_next    = 1'b0;
                    lock_next   = '0;
                end else if (pause_btn && lockout == '0) begin
                    pause_next = 1'b1;
                    lock_next  = LOCK_LOAD;
                end
            end
            default: state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            credit      <= '0;
            paid        <= '0;
            ack_cnt     <= '0;
            lockout     <= '0;
            start       <= 1'b0;
            double_wash <= 1'b0;
            dry_wash    <= 1'b0;
            time_pause  <= 1'b0;
            refund      <= 1'b0;
            refund_amt  <= '0;
            err_funds   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_next;
            credit      <= credit_next;
            paid        <= paid_next;
            ack_cnt     <= ack_next;
            lockout     <= lock_next;
            start       <= start_next;
            double_wash <= double_next;
            dry_wash    <= dry_next;
            time_pause  <= pause_next;
            refund      <= refund_next;
            refund_amt  <= refund_amt_next;
            err_funds   <= err_next;
            busy        <= busy_next;
        end
    end
endmodule

// File: doc/wash_control_panel.md
Name: wash_control_panel

Overview:
- Front-panel and payment controller that sits directly upstream of the washing-machine FSM and drives its start, double_wash, dry_wash and time_pause inputs.
- Accumulates coin credit, prices the selected program, and issues a single-cycle start pulse when the machine reports done.
- Holds the program selection stable for the whole run and rate-limits pause requests.
- Refunds credit on cancel or on a failed launch.

Parameters:
- CREDIT_W, 4, width of credit and refund_amt.
- PRICE_NORMAL, 2, credits for a single wash.
- PRICE_DOUBLE, 3, credits for a double wash.
- PRICE_DRY, 2, credits for steam clean (dry overrides double).
- ACK_TIMEOUT, 4, cycles to wait for done to fall after start.
- PAUSE_LOCKOUT, 24, cycles after an issued pause during which pause_btn is ignored.

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- coin  in  1  one-cycle pulse, +1 credit
- sel_double  in  1  live user selection, double wash
- sel_dry  in  1  live user selection, steam/dry program
- start_btn  in  1  one-cycle pulse, launch request
- pause_btn  in  1  one-cycle pulse, pause request
- cancel_btn  in  1  one-cycle pulse, refund request
- done  in  1  from machine; 1 = machine idle
- start  out  1  one-cycle launch pulse to machine
- double_wash  out  1  latched program bit to machine
- dry_wash  out  1  latched program bit to machine
- time_pause  out  1  one-cycle pause pulse to machine
- credit  out  CREDIT_W  current credit
- refund  out  1  one-cycle refund strobe
- refund_amt  out  CREDIT_W  valid when refund=1, else 0
- err_funds  out  1  one-cycle pulse, start rejected
- busy  out  1  high in LAUNCH, WAIT_ACK, RUN

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE, credit=0, all outputs 0, lockout counter=0, ack counter=0. Reset mid-run drops everything with no refund.
- Price selection: price = PRICE_DRY if sel_dry, else PRICE_DOUBLE if sel_double, else PRICE_NORMAL. Sampled in the cycle start_btn is seen.
- Credit:
  - Saturates at 2^CREDIT_W-1; a coin at saturation is discarded.
  - Subtraction never wraps, because a launch requires credit >= price.
  - Coin is accepted in every state.
- IDLE:
  - start_btn with credit >= price and done=1: latch double_wash=sel_double&~sel_dry and dry_wash=sel_dry, credit -= price, go to LAUNCH.
  - start_btn with credit < price, or with done=0: err_funds pulse next cycle; stay in IDLE; credit unchanged.
  - cancel_btn: refund=1, refund_amt=credit, credit=0 (next cycle).
  - start_btn and cancel_btn in the same cycle: cancel wins, no launch.
- LAUNCH (1 cycle): start=1. double_wash and dry_wash are already valid this cycle. Then go to WAIT_ACK with ack counter=0.
- WAIT_ACK:
  - done=0: go to RUN.
  - ACK_TIMEOUT cycles pass with done=1: refund=1, refund_amt=price paid, clear the latched bits, go to IDLE. Credit is not re-added.
- RUN:
  - double_wash and dry_wash are held constant.
  - pause_btn with lockout=0: time_pause=1 for exactly one cycle (next cycle); lockout loads PAUSE_LOCKOUT and decrements to 0.
  - pause_btn with lockout != 0: ignored.
  - cancel_btn: ignored.
  - done rises to 1: clear double_wash and dry_wash, go to IDLE. Lockout is forced to 0.
- Simultaneous events:
  - coin + successful start: credit_next = credit - price + 1 (saturating). Comparison uses pre-coin credit.
  - coin + cancel: refund_amt = credit+1 (saturating), credit_next = 0.
- Latency: start_btn to start is 1 cycle (registered); pause_btn to time_pause is 1 cycle.
- Outputs are registered; start, time_pause, refund and err_funds are never high for two consecutive cycles.

Test Plan:
- 2 coins, sel_* = 0, start_btn, done=1 -> start pulses 1 cycle later; credit 2->0; double_wash=0, dry_wash=0; busy=1; done=0 next -> RUN.
- 3 coins, sel_double=1, sel_dry=1, start -> dry_wash=1, double_wash=0, credit 3->1. Machine holds done=0 for 30 cycles then 1 -> IDLE, latched bits cleared, credit stays 1.
- 1 coin, start_btn (normal) -> err_funds pulse, no start, credit=1. Then cancel_btn -> refund=1, refund_amt=1, credit=0.
- In RUN, pause_btn at t and t+5, then at t+26 -> time_pause pulses at t+1 and t+27 only.
- 3 coins, start with done held 1 for 6 cycles -> start pulse, then refund=1 with refund_amt=2 after 4 WAIT_ACK cycles; credit=1, state IDLE.
- 15 coins, then coin together with start (price 2) -> credit 15->14. Assert rst during RUN -> every output and credit 0 on the next cycle.
